// File: rtl/xnor_bist_pkg.sv
// Shared types and constants for the XNOR cell BIST: FSM states, the stimulus
// table, expected responses and the delay counter width.
package xnor_bist_pkg;

   localparam int CNT_W   = 8;
   localparam int NUM_VEC = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_HOLD,
      S_DONE
   } state_t;

   // Entry i is {A,B} for vector i: 11, 01, 10, 00
   localparam logic [NUM_VEC-1:0][1:0] VEC_TABLE = {2'b00, 2'b10, 2'b01, 2'b11};
   // Bit i is the good-cell response (A==B) to vector i
   localparam logic [NUM_VEC-1:0] EXP_TABLE = 4'b1001;

   function automatic logic exp_c(input logic [1:0] idx);
      return EXP_TABLE[idx];
   endfunction

endpackage

// File: rtl/xnor_bist_if.sv
// Signal bundle between the BIST controller and the cell/test environment.
interface xnor_bist_if;
   import xnor_bist_pkg::*;

   logic                 start;
   logic                 A;
   logic                 B;
   logic                 C;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [NUM_VEC-1:0]   fail_mask;
   logic [1:0]           vec_idx;

   modport master (
      input  start, C,
      output A, B, busy, done, pass, fail_mask, vec_idx
   );

   modport slave (
      output start, C,
      input  A, B, busy, done, pass, fail_mask, vec_idx
   );

endinterface

// File: rtl/bist_delay_cnt.sv
// Loadable down-counter with a zero flag; times both the settle and hold phases.
module bist_delay_cnt
   import xnor_bist_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/xnor_bist.sv
// Four-vector BIST for a two-input XNOR cell: applies each vector, waits to
// settle, samples C, holds, and reports a per-vector fail mask plus pass.
module xnor_bist
   import xnor_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 15
) (
   input logic         clk,
   input logic         rst_n,
   xnor_bist_if.master bus
);

   // A phase of N cycles loads N-1 and leaves when the counter reads zero
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

   state_t             state, state_nxt;
   logic [1:0]         vec_idx, apply_idx;
   logic               a_q, b_q, pass_q;
   logic [NUM_VEC-1:0] fail_mask, fail_mask_nxt;
   logic               launch, apply, sample, adv, finish, last, miss;
   logic               cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]   cnt_val;

   bist_delay_cnt u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   assign last = (vec_idx == 2'd3);
   // Case-equality so an undriven or X response is flagged as a mismatch
   assign miss = (bus.C !== exp_c(vec_idx));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      apply     = 1'b0;
      apply_idx = vec_idx;
      sample    = 1'b0;
      adv       = 1'b0;
      finish    = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = SETTLE_LD;
      cnt_dec   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               launch    = 1'b1;
               apply     = 1'b1;
               apply_idx = '0;
               cnt_load  = 1'b1;
               state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_zero) state_nxt = S_SAMPLE;
            else          cnt_dec   = 1'b1;
         end
         S_SAMPLE: begin
            sample = 1'b1;
            if (HOLD_CYCLES == 0) begin
               adv = 1'b1;
            end else begin
               cnt_load  = 1'b1;
               cnt_val   = HOLD_LD;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt_zero) adv     = 1'b1;
            else          cnt_dec = 1'b1;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // End of a vector's period: next vector or wrap up the run
      if (adv) begin
         if (last) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
         end else begin
            apply     = 1'b1;
            apply_idx = vec_idx + 2'd1;
            cnt_load  = 1'b1;
            cnt_val   = SETTLE_LD;
            state_nxt = S_SETTLE;
         end
      end
   end

   always_comb begin
      fail_mask_nxt = fail_mask;
      if (sample && miss) fail_mask_nxt[vec_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_idx   <= '0;
         a_q       <= 1'b0;
         b_q       <= 1'b0;
         fail_mask <= '0;
         pass_q    <= 1'b0;
      end else begin
         if (apply) begin
            vec_idx    <= apply_idx;
            {a_q, b_q} <= VEC_TABLE[apply_idx];
         end
         fail_mask <= launch ? '0 : fail_mask_nxt;
         // fail_mask_nxt so a vector-3 miss sampled on this edge is included
         if (launch)      pass_q <= 1'b0;
         else if (finish) pass_q <= (fail_mask_nxt == '0);
      end
   end

   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.vec_idx   = vec_idx;
   assign bus.fail_mask = fail_mask;
   assign bus.pass      = pass_q;
   assign bus.done      = (state == S_DONE);
   assign bus.busy      = (state == S_SETTLE) || (state == S_SAMPLE) || (state == S_HOLD);

endmodule
